// File: rtl/pll_phase_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_ctrl_pkg
//  Description : Shared types, power-up PLL codes and the sizing helper for
//                the rPLL phase/lock sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package pll_ctrl_pkg;

  // Sequencer states. The explicit 3-bit width keeps the encoding stable
  // across tools.
  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_READY     = 3'd2,
    ST_UPDATE    = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // Power-up dynamic codes. A duty code of 4'b1000 selects 50 % duty.
  localparam logic [3:0] C_DEF_PSDA   = 4'b0000;
  localparam logic [3:0] C_DEF_DUTYDA = 4'b1000;
  localparam logic [3:0] C_DEF_FDLY   = 4'b0000;

  // The shared counter must hold the largest terminal count of the three
  // timed phases.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pll_phase_ctrl_if
//  Description : Level-request / ack-pulse handshake that carries new
//                dynamic PLL codes (phase, duty, fine delay) to the
//                sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface pll_phase_ctrl_if;
  logic       cfg_req;
  logic [3:0] cfg_psda;
  logic [3:0] cfg_dutyda;
  logic [3:0] cfg_fdly;
  logic       cfg_ack;

  // Requester side: holds cfg_req and the codes until cfg_ack.
  modport master (
    output cfg_req, cfg_psda, cfg_dutyda, cfg_fdly,
    input  cfg_ack
  );

  // Sequencer side.
  modport slave (
    input  cfg_req, cfg_psda, cfg_dutyda, cfg_fdly,
    output cfg_ack
  );
endinterface
`default_nettype wire

// File: rtl/pll_phase_ctrl_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : 1-bit multi-flop synchronizer for asynchronous level inputs
//                (PLL lock, camera/LCD status lines). Output latency equals
//                STAGES clock cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  generate
    if (STAGES == 1) begin : g_single
      // Single capture flop, cleared by the synchronous reset.
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= d_i;
      end
    end else begin : g_chain
      // Shift the asynchronous input through the flop chain.
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[STAGES-2:0], d_i};
      end
    end
  endgenerate

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pll_phase_ctrl
//  Description : Gowin rPLL sequencer. Pulses PLL RESET, qualifies LOCK for
//                a stable window, releases the downstream reset, serves
//                dynamic phase/duty/fine-delay updates and re-locks with
//                bounded retries.
//  Revision    : 1.0  initial release
// ============================================================================
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int         RST_CYCLES    = 16,
  parameter int         LOCK_STABLE   = 1024,
  parameter int         LOCK_TIMEOUT  = 270000,
  parameter int         SETTLE_CYCLES = 64,
  parameter int         MAX_RETRY     = 3,
  parameter logic [3:0] DEF_PSDA      = C_DEF_PSDA,
  parameter logic [3:0] DEF_DUTYDA    = C_DEF_DUTYDA,
  parameter logic [3:0] DEF_FDLY      = C_DEF_FDLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [3:0]       pll_psda,
  output logic [3:0]       pll_dutyda,
  output logic [3:0]       pll_fdly,
  pll_phase_ctrl_if.slave  cfg,
  output logic             sys_rst,
  output logic             locked,
  output logic             fail,
  output logic [1:0]       retry_cnt
);

  localparam int C_CNT_W  = cnt_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int C_STAB_W = $clog2(LOCK_STABLE + 1);

  // Terminal values: each timed phase lasts exactly N cycles (count 0..N-1).
  localparam logic [C_CNT_W-1:0]  C_RST_LAST    = C_CNT_W'(RST_CYCLES - 1);
  localparam logic [C_CNT_W-1:0]  C_TO_LAST     = C_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [C_CNT_W-1:0]  C_SETTLE_LAST = C_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [C_STAB_W-1:0] C_STAB_LAST   = C_STAB_W'(LOCK_STABLE - 1);
  localparam logic [1:0]          C_MAX_RETRY   = 2'(MAX_RETRY);

  logic                lock_s;
  state_t              state_q,  state_d;
  logic [C_CNT_W-1:0]  cnt_q,    cnt_d;
  logic [C_STAB_W-1:0] stab_q,   stab_d;
  logic [1:0]          retry_q,  retry_d;
  logic [3:0]          psda_q,   psda_d;
  logic [3:0]          duty_q,   duty_d;
  logic [3:0]          fdly_q,   fdly_d;
  logic                ack_now;

  sync_2ff #(
    .STAGES (2)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_lock),
    .q_o (lock_s)
  );

  // State, counters and the applied PLL codes; rst restores power-up values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PLL_RST;
      cnt_q   <= '0;
      stab_q  <= '0;
      retry_q <= '0;
      psda_q  <= DEF_PSDA;
      duty_q  <= DEF_DUTYDA;
      fdly_q  <= DEF_FDLY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stab_q  <= stab_d;
      retry_q <= retry_d;
      psda_q  <= psda_d;
      duty_q  <= duty_d;
      fdly_q  <= fdly_d;
    end
  end

  // Next-state logic; the shared counter is cleared on every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    stab_d  = stab_q;
    retry_d = retry_q;
    psda_d  = psda_q;
    duty_d  = duty_q;
    fdly_d  = fdly_q;
    ack_now = 1'b0;

    case (state_q)
      ST_PLL_RST: begin
        stab_d = '0;
        if (cnt_q == C_RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end

      ST_WAIT_LOCK: begin
        // A low lock sample restarts the stability run but not the timeout.
        stab_d = lock_s ? stab_q + 1'b1 : '0;
        if (lock_s && (stab_q == C_STAB_LAST)) begin
          state_d = ST_READY;
          cnt_d   = '0;
          stab_d  = '0;
        end else if (cnt_q == C_TO_LAST) begin
          cnt_d  = '0;
          stab_d = '0;
          if (retry_q == C_MAX_RETRY) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = ST_PLL_RST;
          end
        end
      end

      ST_READY: begin
        cnt_d = '0;
        // Lock loss outranks a simultaneous request; lock loss is not a retry.
        if (!lock_s) begin
          state_d = ST_PLL_RST;
        end else if (cfg.cfg_req) begin
          psda_d  = cfg.cfg_psda;
          duty_d  = cfg.cfg_dutyda;
          fdly_d  = cfg.cfg_fdly;
          state_d = ST_UPDATE;
        end
      end

      ST_UPDATE: begin
        // New codes stay applied on abort; the level request is re-served.
        if (!lock_s) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end else if (cnt_q == C_SETTLE_LAST) begin
          ack_now = 1'b1;
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end

      ST_FAIL: begin
        cnt_d = '0;
      end

      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
        stab_d  = '0;
      end
    endcase
  end

  assign pll_reset   = (state_q == ST_PLL_RST) || (state_q == ST_FAIL);
  assign locked      = (state_q == ST_READY)   || (state_q == ST_UPDATE);
  assign sys_rst     = !locked;
  assign fail        = (state_q == ST_FAIL);
  assign retry_cnt   = retry_q;
  assign pll_psda    = psda_q;
  assign pll_dutyda  = duty_q;
  assign pll_fdly    = fdly_q;
  assign cfg.cfg_ack = ack_now;

endmodule
`default_nettype wire

// File: tb/tb_pll_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_phase_ctrl
//  Description : Self-checking bench for pll_phase_ctrl with an elapsed-time
//                reference model, directed scenarios and a random phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pll_phase_ctrl;

  localparam int P_RST    = 4;
  localparam int P_STABLE = 8;
  localparam int P_TO     = 64;
  localparam int P_SETTLE = 4;
  localparam int P_MAXR   = 2;

  localparam int M_RST   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_READY = 2;
  localparam int M_UPD   = 3;
  localparam int M_FAIL  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic [3:0] pll_psda, pll_dutyda, pll_fdly;
  logic       sys_rst, locked, fail;
  logic [1:0] retry_cnt;

  pll_phase_ctrl_if cfg_if ();

  pll_phase_ctrl #(
    .RST_CYCLES    (P_RST),
    .LOCK_STABLE   (P_STABLE),
    .LOCK_TIMEOUT  (P_TO),
    .SETTLE_CYCLES (P_SETTLE),
    .MAX_RETRY     (P_MAXR),
    .DEF_PSDA      (4'b0000),
    .DEF_DUTYDA    (4'b1000),
    .DEF_FDLY      (4'b0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_psda   (pll_psda),
    .pll_dutyda (pll_dutyda),
    .pll_fdly   (pll_fdly),
    .cfg        (cfg_if),
    .sys_rst    (sys_rst),
    .locked     (locked),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_seen = 0;

  // Reference model: operating mode, cycles spent in it, lock run length.
  int         m_mode  = M_RST;
  int         m_t     = 0;
  int         m_stab  = 0;
  int         m_retry = 0;
  logic       m_lk_p1 = 1'b0;
  logic       m_lk_s  = 1'b0;
  logic [3:0] m_psda  = 4'h0;
  logic [3:0] m_duty  = 4'h8;
  logic [3:0] m_fdly  = 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic s_rst, input logic s_lock, input logic s_req,
                            input logic [3:0] s_ps, input logic [3:0] s_du,
                            input logic [3:0] s_fd);
    logic lk;
    lk = m_lk_s;
    if (s_rst) begin
      m_mode = M_RST; m_t = 0; m_stab = 0; m_retry = 0;
      m_psda = 4'h0; m_duty = 4'h8; m_fdly = 4'h0;
      m_lk_p1 = 1'b0; m_lk_s = 1'b0;
      return;
    end
    case (m_mode)
      M_RST: begin
        m_t++;
        if (m_t == P_RST) begin m_mode = M_WAIT; m_t = 0; m_stab = 0; end
      end
      M_WAIT: begin
        m_t++;
        m_stab = lk ? m_stab + 1 : 0;
        if (m_stab == P_STABLE) begin
          m_mode = M_READY; m_t = 0;
        end else if (m_t == P_TO) begin
          m_t = 0;
          if (m_retry == P_MAXR) m_mode = M_FAIL;
          else begin m_retry++; m_mode = M_RST; end
        end
      end
      M_READY: begin
        if (!lk) begin m_mode = M_RST; m_t = 0; end
        else if (s_req) begin
          m_psda = s_ps; m_duty = s_du; m_fdly = s_fd;
          m_mode = M_UPD; m_t = 0;
        end
      end
      M_UPD: begin
        if (!lk) begin m_mode = M_RST; m_t = 0; end
        else begin
          m_t++;
          if (m_t == P_SETTLE) begin m_mode = M_READY; m_t = 0; end
        end
      end
      default: ;
    endcase
    m_lk_s  = m_lk_p1;
    m_lk_p1 = s_lock;
  endtask

  // One clock: update the model with the inputs seen at the edge, then
  // compare every output a little after the edge.
  task automatic step();
    logic s_rst, s_lock, s_req;
    logic [3:0] s_ps, s_du, s_fd;
    logic e_lock;
    s_rst = rst; s_lock = pll_lock; s_req = cfg_if.cfg_req;
    s_ps = cfg_if.cfg_psda; s_du = cfg_if.cfg_dutyda; s_fd = cfg_if.cfg_fdly;
    @(posedge clk);
    model_edge(s_rst, s_lock, s_req, s_ps, s_du, s_fd);
    #1;
    e_lock = (m_mode == M_READY) || (m_mode == M_UPD);
    chk("pll_reset", 32'(pll_reset), 32'((m_mode == M_RST) || (m_mode == M_FAIL)));
    chk("sys_rst",   32'(sys_rst),   32'(!e_lock));
    chk("locked",    32'(locked),    32'(e_lock));
    chk("fail",      32'(fail),      32'(m_mode == M_FAIL));
    chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
    chk("pll_psda",  32'(pll_psda),  32'(m_psda));
    chk("pll_dutyda",32'(pll_dutyda),32'(m_duty));
    chk("pll_fdly",  32'(pll_fdly),  32'(m_fdly));
    chk("cfg_ack",   32'(cfg_if.cfg_ack),
        32'((m_mode == M_UPD) && (m_t == P_SETTLE - 1) && m_lk_s));
    if (cfg_if.cfg_ack === 1'b1) ack_seen++;
  endtask

  task automatic set_req(input logic r, input logic [3:0] p, input logic [3:0] d,
                         input logic [3:0] f);
    cfg_if.cfg_req = r; cfg_if.cfg_psda = p; cfg_if.cfg_dutyda = d; cfg_if.cfg_fdly = f;
  endtask

  initial begin
    int k, pr, r1, r2;
    set_req(1'b0, 4'h0, 4'h0, 4'h0);
    rst = 1'b1; pll_lock = 1'b0;

    // ---- power-up ----
    repeat (3) step();
    chk("rst_dutyda", 32'(pll_dutyda), 32'h8);
    chk("rst_pll_reset", 32'(pll_reset), 32'h1);
    chk("rst_retry", 32'(retry_cnt), 32'h0);
    rst = 1'b0;
    repeat (3) step();
    chk("pll_reset_held", 32'(pll_reset), 32'h1);
    step();
    chk("pll_reset_release", 32'(pll_reset), 32'h0);
    repeat (3) step();
    pll_lock = 1'b1;
    k = 0;
    while (locked !== 1'b1 && k < 40) begin step(); k++; end
    chk("powerup_lock_latency", 32'(k), 32'd10);
    chk("powerup_dutyda", 32'(pll_dutyda), 32'h8);

    // ---- lock glitch during the stability window ----
    pll_lock = 1'b0;
    k = 0;
    while (pll_reset !== 1'b1 && k < 10) begin step(); k++; end
    k = 0;
    while (pll_reset !== 1'b0 && k < 20) begin step(); k++; end
    pll_lock = 1'b1;
    repeat (7) step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    k = 0;
    while (locked !== 1'b1 && k < 40) begin step(); k++; end
    chk("glitch_lock_latency", 32'(k), 32'd10);
    chk("lockloss_no_retry", 32'(retry_cnt), 32'h0);

    // ---- dynamic update ----
    ack_seen = 0;
    set_req(1'b1, 4'h3, 4'h6, 4'h1);
    step();
    chk("upd_psda", 32'(pll_psda), 32'h3);
    chk("upd_dutyda", 32'(pll_dutyda), 32'h6);
    chk("upd_fdly", 32'(pll_fdly), 32'h1);
    k = 1;
    while (cfg_if.cfg_ack !== 1'b1 && k < 20) begin step(); k++; end
    chk("upd_ack_latency", 32'(k), 32'd4);
    cfg_if.cfg_req = 1'b0;
    repeat (2) step();
    chk("upd_single_ack", 32'(ack_seen), 32'd1);
    chk("upd_sys_rst", 32'(sys_rst), 32'h0);

    // ---- lock loss in the middle of an update ----
    ack_seen = 0;
    set_req(1'b1, 4'h3, 4'h7, 4'h2);
    repeat (2) step();
    pll_lock = 1'b0;
    k = 0;
    while (sys_rst !== 1'b1 && k < 10) begin step(); k++; end
    chk("loss_sys_rst_within_3", 32'(k <= 3), 32'h1);
    chk("loss_no_ack", 32'(ack_seen), 32'd0);
    pr = (pll_reset === 1'b1) ? 1 : 0;
    pll_lock = 1'b1;
    k = 0;
    while (locked !== 1'b1 && k < 100) begin
      step(); k++;
      if (pll_reset === 1'b1) pr++;
    end
    chk("loss_pll_reset_pulse", 32'(pr), 32'd4);
    k = 0;
    while (ack_seen == 0 && k < 40) begin step(); k++; end
    chk("loss_reserved_ack", 32'(ack_seen), 32'd1);
    chk("loss_psda_kept", 32'(pll_psda), 32'h3);
    chk("loss_dutyda_new", 32'(pll_dutyda), 32'h7);
    cfg_if.cfg_req = 1'b0;
    step();

    // ---- random lock/request traffic against the model ----
    for (int i = 0; i < 600; i++) begin
      pll_lock = ($urandom_range(0, 99) >= 3);
      set_req(($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom), 4'($urandom));
      step();
    end
    set_req(1'b0, 4'h0, 4'h0, 4'h0);

    // ---- timeouts, retries and the sticky fail ----
    rst = 1'b1; pll_lock = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    k = 0; r1 = -1; r2 = -1;
    while (fail !== 1'b1 && k < 400) begin
      step(); k++;
      if (k == 68)  r1 = int'(retry_cnt);
      if (k == 136) r2 = int'(retry_cnt);
    end
    chk("timeout_first_retry", 32'(r1), 32'd1);
    chk("timeout_second_retry", 32'(r2), 32'd2);
    chk("fail_latency", 32'(k), 32'd204);
    chk("fail_pll_reset", 32'(pll_reset), 32'h1);
    pll_lock = 1'b1;
    repeat (30) step();
    chk("fail_sticky", 32'(fail), 32'h1);
    chk("fail_not_locked", 32'(locked), 32'h0);

    // ---- reset in the middle of an update ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    k = 0;
    while (locked !== 1'b1 && k < 60) begin step(); k++; end
    set_req(1'b1, 4'h5, 4'h2, 4'h9);
    repeat (2) step();
    ack_seen = 0;
    rst = 1'b1;
    step();
    chk("midrst_psda", 32'(pll_psda), 32'h0);
    chk("midrst_dutyda", 32'(pll_dutyda), 32'h8);
    chk("midrst_fdly", 32'(pll_fdly), 32'h0);
    chk("midrst_sys_rst", 32'(sys_rst), 32'h1);
    chk("midrst_locked", 32'(locked), 32'h0);
    chk("midrst_fail", 32'(fail), 32'h0);
    rst = 1'b0;
    cfg_if.cfg_req = 1'b0;
    repeat (10) step();
    chk("midrst_no_ack", 32'(ack_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
